// File: rtl/serial_add_pkg.sv
// Shared types and helpers for the bit-serial add/subtract sequencer.
package serial_add_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam int unsigned DEFAULT_WIDTH = 16;

   // Counter must hold WIDTH-1 without wrapping; never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned width);
      return (width < 2) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/full_adder_cell.sv
// Single-bit full adder built from two half adders; the only arithmetic in the sequencer.
module full_adder_cell (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   logic w_s0;
   logic w_c0;
   logic w_c1;

   half_adder u_ha0 (
      .i_a     (a),
      .i_b     (b),
      .o_sum   (w_s0),
      .o_carry (w_c0)
   );

   half_adder u_ha1 (
      .i_a     (w_s0),
      .i_b     (cin),
      .o_sum   (sum),
      .o_carry (w_c1)
   );

   assign cout = w_c0 | w_c1;

endmodule

// File: rtl/half_adder.sv
// Single-bit half adder.
module half_adder (
   input  logic i_a,
   input  logic i_b,
   output logic o_sum,
   output logic o_carry
);

   assign o_sum   = i_a ^ i_b;
   assign o_carry = i_a & i_b;

endmodule

// File: rtl/serial_add_sequencer.sv
// Bit-serial WIDTH-bit add/subtract: one full-adder cell stepped LSB first, start/done handshake.
module serial_add_sequencer
   import serial_add_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             op_sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             carry_out,
   output logic             overflow,
   output logic             zero
);

   localparam int unsigned     CNT_W    = cnt_width(WIDTH);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] PRE_MSB  = CNT_W'(WIDTH - 2);

   state_t             r_state;
   state_t             w_next;
   logic [WIDTH-1:0]   r_op_a;
   logic [WIDTH-1:0]   r_op_b;
   logic [WIDTH-2:0]   r_part;
   logic               r_carry;
   logic               r_c_msb;
   logic [CNT_W-1:0]   r_cnt;
   logic [WIDTH-1:0]   r_result;
   logic               r_carry_out;
   logic               r_overflow;
   logic               r_zero;

   logic               w_sum;
   logic               w_cout;
   logic               w_accept;
   logic               w_last;
   logic [WIDTH-1:0]   w_final;

   full_adder_cell u_fa (
      .a    (r_op_a[0]),
      .b    (r_op_b[0]),
      .cin  (r_carry),
      .sum  (w_sum),
      .cout (w_cout)
   );

   assign w_accept = start && (r_state == IDLE || r_state == DONE);
   assign w_last   = (r_state == RUN) && (r_cnt == LAST_BIT);
   // Partial holds the low bits already produced; the new sum bit lands on top.
   assign w_final  = {w_sum, r_part};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE:    w_next = start ? RUN : IDLE;
         RUN:     w_next = w_last ? DONE : RUN;
         DONE:    w_next = start ? RUN : IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_comb begin
      busy = (r_state == RUN);
      done = (r_state == DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_op_a      <= '0;
         r_op_b      <= '0;
         r_part      <= '0;
         r_carry     <= 1'b0;
         r_c_msb     <= 1'b0;
         r_cnt       <= '0;
         r_result    <= '0;
         r_carry_out <= 1'b0;
         r_overflow  <= 1'b0;
         r_zero      <= 1'b0;
      end else if (w_accept) begin
         r_op_a  <= a;
         r_op_b  <= op_sub ? ~b : b;
         r_part  <= '0;
         r_carry <= op_sub;
         r_c_msb <= 1'b0;
         r_cnt   <= '0;
      end else if (r_state == RUN) begin
         r_op_a  <= r_op_a >> 1;
         r_op_b  <= r_op_b >> 1;
         r_part  <= w_final[WIDTH-1:1];
         r_carry <= w_cout;
         r_cnt   <= r_cnt + 1'b1;
         // Cell carry-out of bit WIDTH-2 is the carry into the MSB.
         if (r_cnt == PRE_MSB) begin
            r_c_msb <= w_cout;
         end
         if (w_last) begin
            r_result    <= w_final;
            r_carry_out <= w_cout;
            r_overflow  <= r_c_msb ^ w_cout;
            r_zero      <= (w_final == '0);
         end
      end
   end

   assign result    = r_result;
   assign carry_out = r_carry_out;
   assign overflow  = r_overflow;
   assign zero      = r_zero;

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Scoreboard bench for serial_add_sequencer: stimulus pushes model results, a monitor checks on done.
module tb_serial_add_sequencer;

   typedef struct {
      logic [15:0] r;
      logic        c;
      logic        v;
      logic        z;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        op_sub;
   logic [15:0] a;
   logic [15:0] b;
   logic        busy;
   logic        done;
   logic [15:0] result;
   logic        carry_out;
   logic        overflow;
   logic        zero;

   int   n_checks = 0;
   int   n_fail   = 0;
   exp_t q[$];

   serial_add_sequencer #(.WIDTH(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .op_sub    (op_sub),
      .a         (a),
      .b         (b),
      .busy      (busy),
      .done      (done),
      .result    (result),
      .carry_out (carry_out),
      .overflow  (overflow),
      .zero      (zero)
   );

   always #5 clk = ~clk;

   // Integer-arithmetic reference: two's-complement add/sub with signed range check.
   function automatic exp_t model(input logic [15:0] ia, input logic [15:0] ib, input logic sub);
      exp_t        e;
      int unsigned ua;
      int unsigned ub;
      int unsigned full;
      int          sa;
      int          sb;
      int          s;
      ua = 32'(ia);
      ub = 32'(ib);
      sa = $signed(ia);
      sb = $signed(ib);
      if (sub) begin
         full = ua + (ub ^ 32'hFFFF) + 1;
         s    = sa - sb;
      end else begin
         full = ua + ub;
         s    = sa + sb;
      end
      e.r = full[15:0];
      e.c = full[16];
      e.v = (s > 32767) || (s < -32768);
      e.z = (e.r == 16'h0000);
      return e;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (!rst && done) begin
         if (q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_done: got done=1 expected no pending op at %0t", $time);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("result", 32'(result), 32'(e.r));
            chk("carry_out", 32'(carry_out), 32'(e.c));
            chk("overflow", 32'(overflow), 32'(e.v));
            chk("zero", 32'(zero), 32'(e.z));
         end
      end
   end

   // Called at 1 time unit after an edge; returns at 1 time unit after the start edge.
   task automatic issue(input logic [15:0] ia, input logic [15:0] ib, input logic sub);
      start  = 1'b1;
      a      = ia;
      b      = ib;
      op_sub = sub;
      @(posedge clk);
      q.push_back(model(ia, ib, sub));
      #1 start = 1'b0;
   endtask

   // Waits for done; optionally pulses a stray start while busy at cycle inject_at.
   task automatic wait_done(input int inject_at);
      int lat = 0;
      int busy_cnt = 0;
      while (!done && lat < 40) begin
         if (lat == inject_at) begin
            start  = 1'b1;
            a      = 16'hAAAA;
            b      = 16'h5555;
            op_sub = 1'b0;
         end else if (lat == inject_at + 1) begin
            start = 1'b0;
         end
         if (busy) busy_cnt++;
         @(posedge clk);
         #1;
         lat++;
      end
      chk("latency", 32'(lat), 32'd16);
      chk("busy_cycles", 32'(busy_cnt), 32'd16);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      int done_seen;
      rst    = 1'b1;
      start  = 1'b0;
      op_sub = 1'b0;
      a      = '0;
      b      = '0;
      #3;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_result", 32'(result), 32'd0);
      chk("rst_flags", {29'd0, carry_out, overflow, zero}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      idle(1);

      // Directed cases
      issue(16'h0001, 16'h0001, 1'b0);
      wait_done(-1);
      idle(1);
      chk("done_one_cycle", 32'(done), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("result_holds", 32'(result), 32'h0002);
      issue(16'hFFFF, 16'h0001, 1'b0);
      wait_done(-1);
      issue(16'h7FFF, 16'h0001, 1'b0);
      wait_done(-1);
      idle(2);
      issue(16'h8000, 16'h0001, 1'b1);
      wait_done(-1);
      issue(16'h0005, 16'h0007, 1'b1);
      wait_done(-1);
      idle(1);
      issue(16'h1234, 16'h1234, 1'b1);
      wait_done(-1);
      idle(1);

      // Stray start while busy, then back-to-back start in the done cycle
      issue(16'h0001, 16'h0001, 1'b0);
      wait_done(5);
      issue(16'h1357, 16'h0246, 1'b1);
      wait_done(-1);
      idle(1);

      for (int i = 0; i < 24; i++) begin
         logic [15:0] ra;
         logic [15:0] rb;
         ra = 16'($urandom);
         rb = 16'($urandom);
         if (i % 6 == 0) rb = ra;
         issue(ra, rb, 1'($urandom));
         wait_done(-1);
         idle(int'($urandom_range(0, 2)));
      end

      // Asynchronous reset mid-operation
      issue(16'h7FFF, 16'h0001, 1'b0);
      wait_done(-1);
      idle(1);
      issue(16'h1111, 16'h2222, 1'b0);
      idle(8);
      #2 rst = 1'b1;
      #1;
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_done", 32'(done), 32'd0);
      chk("arst_result", 32'(result), 32'd0);
      chk("arst_flags", {29'd0, carry_out, overflow, zero}, 32'd0);
      q.delete();
      idle(2);
      @(negedge clk);
      rst = 1'b0;
      done_seen = 0;
      repeat (30) begin
         @(negedge clk);
         if (done || busy) done_seen++;
      end
      chk("no_done_after_rst", 32'(done_seen), 32'd0);
      @(posedge clk);
      #1;
      issue(16'h4000, 16'h4000, 1'b0);
      wait_done(-1);
      idle(3);

      chk("scoreboard_empty", 32'(q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/serial_add_sequencer.md
Name: serial_add_sequencer

Overview:
Multi-cycle 16-bit add/subtract unit that sequences a single 1-bit full-adder cell over the operand bits, LSB first. It is used where area matters more than latency, e.g. address/offset arithmetic beside the main ALU. It uses a start/done handshake and produces registered result and flags: carry, signed overflow and zero.

Parameters:
WIDTH, 16, operand/result width in bits (≥2)

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled only when not busy
op_sub  input  1  0 = a+b, 1 = a−b; sampled with start
a  input  WIDTH  operand A; sampled with start
b  input  WIDTH  operand B; sampled with start
busy  output  1  high while bits are being processed
done  output  1  one-cycle pulse: result/flags valid and updated
result  output  WIDTH  sum/difference; holds until next completion
carry_out  output  1  final carry (sub: 1 = no borrow)
overflow  output  1  signed overflow: carry into MSB XOR carry out of MSB
zero  output  1  result == 0

Behaviour:
- Reset (async, any time, including mid-operation):
  - state=IDLE; busy=0, done=0, result=0, carry_out=0, overflow=0, zero=0.
  - Internal operand registers, carry and bit counter cleared.
  - No done pulse follows a reset.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at edge → latch a into opA and (op_sub ? ~b : b) into opB.
  - carry reg = op_sub; bit counter = 0; go to RUN.
- RUN (busy=1):
  - Each edge feeds opA[0], opB[0] and carry into full_adder_cell.
  - Sum is shifted into the MSB of a partial-result shift register; opA and opB shift right; carry reg ← cell cout.
  - When counter == WIDTH−2 at an edge, capture the current carry as c_into_msb.
  - Counter increments each edge.
  - At the edge processing bit WIDTH−1, go to DONE and load the output registers:
    - result = final partial register.
    - carry_out = cell cout.
    - overflow = c_into_msb XOR cell cout.
    - zero = (final result == 0).
- DONE:
  - done=1 for exactly one cycle; busy=0.
  - start=1 in this cycle is accepted as in IDLE (back-to-back) → RUN.
  - Otherwise go to IDLE.
- Latency: start sampled at edge E0 → busy high in the cycles after E0..E(WIDTH−1) → done high in the cycle after edge E(WIDTH); throughput one op per WIDTH+1 cycles.
- start while busy: ignored. Operands and op_sub changing while busy have no effect.
- result and flags change only on the completion edge; they hold through IDLE and during a following RUN.
- Counter width: $clog2(WIDTH); counter must not wrap within an operation.

Decomposition:
- Shared package `serial_add_pkg`: state enum {IDLE, RUN, DONE}, default WIDTH=16, counter-width function.
- One sub-module: `full_adder_cell` (a, b, cin → sum, cout), built from two half_adder instances plus an OR of their carries. It is instantiated once.

Test Plan:
1. a=0x0001, b=0x0001, add → done exactly 16 edges after the start edge; result=0x0002, carry_out=0, overflow=0, zero=0; busy high for 16 cycles.
2. a=0xFFFF, b=0x0001, add → result=0x0000, carry_out=1, overflow=0, zero=1.
3. a=0x7FFF, b=0x0001, add → result=0x8000, overflow=1, carry_out=0. Then a=0x8000, b=0x0001, sub → result=0x7FFF, overflow=1, carry_out=1.
4. a=0x0005, b=0x0007, sub → result=0xFFFE, carry_out=0 (borrow), overflow=0, zero=0. Then a=0x1234, b=0x1234, sub → result=0x0000, zero=1, carry_out=1.
5. Start the op from test 1, then pulse start with a=0xAAAA, b=0x5555 at cycle 5 → ignored; result=0x0002. Assert start with new operands in the done cycle → accepted; done again 16 edges later with the correct result.
6. Assert rst at cycle 8 of an op → busy, done and all outputs go 0 immediately without waiting for a clock edge. No done pulse occurs after rst releases until a new start.
